// File: rtl/kbd_event_decoder_pkg.sv
// Shared constants for the PS/2 keyboard event decoder:
// scan codes, parser states and event field positions.
package kbd_event_decoder_pkg;

    localparam logic [7:0] SC_E0    = 8'hE0;
    localparam logic [7:0] SC_F0    = 8'hF0;
    localparam logic [7:0] SC_E1    = 8'hE1;
    localparam logic [7:0] SC_LSHFT = 8'h12;
    localparam logic [7:0] SC_RSHFT = 8'h59;
    localparam logic [7:0] SC_CTRL  = 8'h14;
    localparam logic [7:0] SC_CAPS  = 8'h58;

    // Pause (E1 ...) carries seven trailing bytes
    localparam logic [2:0] E1_SKIP_LEN = 3'd7;

    localparam int EVT_W     = 13;
    localparam int EVT_EXT   = 12;
    localparam int EVT_REL   = 11;
    localparam int EVT_SHIFT = 10;
    localparam int EVT_CTRL  = 9;
    localparam int EVT_CAPS  = 8;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        GOT_E0   = 3'd1,
        GOT_F0   = 3'd2,
        GOT_E0F0 = 3'd3,
        SKIP_E1  = 3'd4
    } state_t;

endpackage

// File: rtl/kbd_event_decoder_if.sv
// Byte input and event output handshake bundle.
interface kbd_event_decoder_if;
    import kbd_event_decoder_pkg::*;

    logic             ps2_valid;
    logic [7:0]       ps2_data;
    logic             evt_valid;
    logic             evt_ready;
    logic [EVT_W-1:0] evt_data;

    modport master (
        output ps2_valid, ps2_data, evt_ready,
        input  evt_valid, evt_data
    );

    modport slave (
        input  ps2_valid, ps2_data, evt_ready,
        output evt_valid, evt_data
    );

endinterface

// File: rtl/kbd_event_fifo.sv
// First-word-fall-through event FIFO with occupancy counter.
module kbd_event_fifo #(
    parameter int WIDTH = 13,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign pop_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/kbd_event_decoder.sv
// PS/2 set-2 scan-code parser: tracks modifiers and the held
// extended key, and queues make/release events into a FIFO.
module kbd_event_decoder
    import kbd_event_decoder_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    kbd_event_decoder_if.slave  bus,
    output logic [7:0]          scanCode_E0,
    output logic                shift_held,
    output logic                ctrl_held,
    output logic                caps_lock,
    output logic                overflow
);
    state_t     state, state_n;
    logic [2:0] skip_cnt, skip_cnt_n;
    logic       shift_n, ctrl_n, caps_n;
    logic       caps_down, caps_down_n;
    logic [7:0] e0_n;
    logic       done, ev_ext, ev_rel;
    logic       push, pop, full, empty;
    logic [EVT_W-1:0] push_data;
    logic [7:0] code;

    assign code = bus.ps2_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            skip_cnt    <= '0;
            shift_held  <= 1'b0;
            ctrl_held   <= 1'b0;
            caps_lock   <= 1'b0;
            caps_down   <= 1'b0;
            scanCode_E0 <= 8'h00;
            overflow    <= 1'b0;
        end else begin
            state       <= state_n;
            skip_cnt    <= skip_cnt_n;
            shift_held  <= shift_n;
            ctrl_held   <= ctrl_n;
            caps_lock   <= caps_n;
            caps_down   <= caps_down_n;
            scanCode_E0 <= e0_n;
            if (push && full && !pop) overflow <= 1'b1;
        end
    end

    always_comb begin
        state_n    = state;
        skip_cnt_n = skip_cnt;
        done       = 1'b0;
        ev_ext     = 1'b0;
        ev_rel     = 1'b0;
        if (bus.ps2_valid) begin
            unique case (state)
                IDLE: begin
                    if (code == SC_E0) begin
                        state_n = GOT_E0;
                    end else if (code == SC_F0) begin
                        state_n = GOT_F0;
                    end else if (code == SC_E1) begin
                        state_n    = SKIP_E1;
                        skip_cnt_n = E1_SKIP_LEN;
                    end else begin
                        done = 1'b1;
                    end
                end
                GOT_E0: begin
                    if (code == SC_F0) begin
                        state_n = GOT_E0F0;
                    end else begin
                        // E0 12 / E0 59 are fake shifts and are dropped
                        state_n = IDLE;
                        done    = !(code == SC_LSHFT || code == SC_RSHFT);
                        ev_ext  = 1'b1;
                    end
                end
                GOT_F0: begin
                    state_n = IDLE;
                    done    = 1'b1;
                    ev_rel  = 1'b1;
                end
                GOT_E0F0: begin
                    state_n = IDLE;
                    done    = 1'b1;
                    ev_ext  = 1'b1;
                    ev_rel  = 1'b1;
                end
                SKIP_E1: begin
                    skip_cnt_n = skip_cnt - 3'd1;
                    if (skip_cnt <= 3'd1) state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_comb begin
        shift_n     = shift_held;
        ctrl_n      = ctrl_held;
        caps_n      = caps_lock;
        caps_down_n = caps_down;
        e0_n        = scanCode_E0;
        push        = 1'b0;
        if (done) begin
            if (!ev_ext && (code == SC_LSHFT || code == SC_RSHFT)) begin
                shift_n = !ev_rel;
            end else if (code == SC_CTRL) begin
                ctrl_n = !ev_rel;
            end else if (!ev_ext && code == SC_CAPS) begin
                if (ev_rel) begin
                    caps_down_n = 1'b0;
                end else begin
                    if (!caps_down) caps_n = !caps_lock;
                    caps_down_n = 1'b1;
                end
            end else begin
                push = 1'b1;
            end
            if (ev_ext && !ev_rel) e0_n = code;
            else if (ev_ext && code == scanCode_E0) e0_n = 8'h00;
        end
    end

    assign push_data = {ev_ext, ev_rel, shift_held, ctrl_held,
                        caps_lock, code};
    assign pop = bus.evt_ready & ~empty;
    assign bus.evt_valid = ~empty;

    kbd_event_fifo #(
        .WIDTH (EVT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .pop_data  (bus.evt_data),
        .full      (full),
        .empty     (empty)
    );

endmodule
